router_pkt_tx: RTL

Packet source for the 1x3 router: frames a host-supplied payload into the router's input packet format and drives the router's input port. A packet on the wire is three parts:
- a header byte `{payload_len[5:0], dest_addr[1:0]}`;
- payload bytes;
- a parity byte equal to the XOR of the header and all payload bytes.

The payload is buffered in full before transmission, so the router sees a gap-free packet. The block sits in front of the router's `pkt_valid`/`data_in` inputs and is stalled by the router's `busy`.

---
 rtl/router_pkg.sv | 24 ++
 rtl/router_tx_buf.sv | 26 ++
 rtl/router_pkt_tx.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the router packet source.
// Header byte layout is {payload_len, dest_addr}.
package router_pkg;

  localparam int ADDR_W  = 2;
  localparam int LEN_W   = 6;
  localparam int MAX_LEN = 63;
  localparam logic [ADDR_W-1:0] ADDR_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HEADER,
    ST_PAYLOAD,
    ST_PARITY,
    ST_GAP
  } state_e;

  function automatic logic [7:0] pack_header(input logic [LEN_W-1:0]  len,
                                             input logic [ADDR_W-1:0] addr);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload store for one packet: synchronous write, asynchronous read.
// Storage is deliberately unreset; every read location is written before use.
module router_tx_buf
  import router_pkg::*;
(
  input  logic             clock,
  input  logic             wr_en,
  input  logic [LEN_W-1:0] wr_addr,
  input  logic [7:0]       wr_data,
  input  logic [LEN_W-1:0] rd_addr,
  output logic [7:0]       rd_data
);

  localparam int DEPTH = MAX_LEN + 1;

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/router_pkt_tx.sv
// Frames a fully buffered payload as header/payload/parity for the router input.
// All outputs registered; router busy freezes the presented byte and the FSM.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int IDLE_GAP = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic [LEN_W-1:0]  payload_len,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  input  logic              busy,
  output logic              pkt_valid,
  output logic [7:0]        data_out,
  output logic              tx_active,
  output logic              done,
  output logic              cfg_err
);

  localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IDLE_GAP - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [LEN_W-1:0] CNT_ONE  = LEN_W'(1);

  state_e state_q, state_d;

  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [LEN_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [7:0]        par_q, par_d;
  logic              pkt_valid_q, pkt_valid_d;
  logic [7:0]        data_out_q, data_out_d;
  logic              s_ready_q, s_ready_d;
  logic              tx_active_q, tx_active_d;
  logic              done_q, done_d;
  logic              cfg_err_q, cfg_err_d;

  logic              wr_en;
  logic [LEN_W-1:0]  rd_addr;
  logic [7:0]        rd_data;
  logic [7:0]        hdr;
  logic              cfg_ok;
  logic              taken;
  logic              last_wr;
  logic              last_rd;

  assign hdr     = pack_header(len_q, addr_q);
  assign cfg_ok  = (dest_addr != ADDR_ILLEGAL) && (payload_len != '0);
  assign taken   = !busy && (state_q inside {ST_HEADER, ST_PAYLOAD, ST_PARITY});
  assign last_wr = (wr_cnt_q == len_q - CNT_ONE);
  assign last_rd = (rd_cnt_q == len_q - CNT_ONE);

  // Read address looks one byte ahead so the next byte is ready when the current one is taken.
  always_comb begin
    rd_addr = '0;
    if (state_q == ST_PAYLOAD) begin
      rd_addr = rd_cnt_q + CNT_ONE;
    end
  end

  router_tx_buf u_buf (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wr_cnt_q),
    .wr_data (s_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start && cfg_ok)      state_d = ST_LOAD;
      ST_LOAD:    if (s_valid && last_wr)   state_d = ST_HEADER;
      ST_HEADER:  if (taken)                state_d = ST_PAYLOAD;
      ST_PAYLOAD: if (taken && last_rd)     state_d = ST_PARITY;
      ST_PARITY:  if (taken)                state_d = ST_GAP;
      ST_GAP:     if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
      default:                              state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    len_d       = len_q;
    addr_d      = addr_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    par_d       = par_q;
    pkt_valid_d = pkt_valid_q;
    data_out_d  = data_out_q;
    s_ready_d   = (state_d == ST_LOAD);
    tx_active_d = (state_d != ST_IDLE);
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;
    wr_en       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        gap_cnt_d = '0;
        if (start) begin
          if (cfg_ok) begin
            len_d    = payload_len;
            addr_d   = dest_addr;
            wr_cnt_d = '0;
            rd_cnt_d = '0;
            par_d    = '0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (s_valid) begin
          wr_en    = 1'b1;
          wr_cnt_d = wr_cnt_q + CNT_ONE;
          par_d    = par_q ^ s_data;
          // Fold the header into parity on the final beat so PARITY needs no extra work.
          if (last_wr) begin
            par_d       = par_q ^ s_data ^ hdr;
            data_out_d  = hdr;
            pkt_valid_d = 1'b1;
          end
        end
      end
      ST_HEADER: begin
        if (taken) begin
          rd_cnt_d    = '0;
          data_out_d  = rd_data;
          pkt_valid_d = 1'b1;
        end
      end
      ST_PAYLOAD: begin
        if (taken) begin
          if (last_rd) begin
            data_out_d  = par_q;
            pkt_valid_d = 1'b0;
          end else begin
            rd_cnt_d    = rd_cnt_q + CNT_ONE;
            data_out_d  = rd_data;
            pkt_valid_d = 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (taken) begin
          data_out_d  = '0;
          pkt_valid_d = 1'b0;
          done_d      = 1'b1;
          gap_cnt_d   = '0;
        end
      end
      ST_GAP: begin
        gap_cnt_d   = gap_cnt_q + GAP_ONE;
        data_out_d  = '0;
        pkt_valid_d = 1'b0;
      end
      default: begin
        data_out_d  = '0;
        pkt_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      len_q       <= '0;
      addr_q      <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      gap_cnt_q   <= '0;
      par_q       <= '0;
      pkt_valid_q <= 1'b0;
      data_out_q  <= '0;
      s_ready_q   <= 1'b0;
      tx_active_q <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      len_q       <= len_d;
      addr_q      <= addr_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      par_q       <= par_d;
      pkt_valid_q <= pkt_valid_d;
      data_out_q  <= data_out_d;
      s_ready_q   <= s_ready_d;
      tx_active_q <= tx_active_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign pkt_valid = pkt_valid_q;
  assign data_out  = data_out_q;
  assign s_ready   = s_ready_q;
  assign tx_active = tx_active_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;

endmodule
